// File: rtl/tone_voices_if.sv
// Voice-programming write port: one valid/ready transfer loads a voice.
interface tone_voices_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 17,
    parameter int VOL_W    = 4,
    parameter int DUR_W    = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic [VOL_W-1:0] wr_vol;
    logic [DUR_W-1:0] wr_dur;

    modport master (
        output wr_valid, wr_ch, wr_div, wr_vol, wr_dur,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_ch, wr_div, wr_vol, wr_dur,
        output wr_ready
    );
endinterface

// File: rtl/tone_voices.sv
// Multi-voice square-wave tone synthesiser with a first-order sigma-delta
// output for a single speaker pin.
module tone_voices #(
    parameter int CLK_HZ   = 12000000,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 17,
    parameter int VOL_W    = 4,
    parameter int DUR_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    tone_voices_if.slave        wr,
    output logic                speaker,
    output logic [CHANNELS-1:0] active,
    output logic [CHANNELS-1:0] done
);
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MIX_W    = (CHANNELS > 1) ? VOL_W + $clog2(CHANNELS) : VOL_W + 1;
    localparam int PRESCALE = CLK_HZ / 1000;
    localparam int PS_W     = $clog2(PRESCALE);

    logic [PS_W-1:0]  ps_cnt;
    logic             ms_tick;
    logic             wr_fire;

    logic [DIV_W-1:0] div_r   [CHANNELS];
    logic [VOL_W-1:0] vol_r   [CHANNELS];
    logic [DIV_W-1:0] phase   [CHANNELS];
    logic [DUR_W-1:0] dur_cnt [CHANNELS];
    logic [CHANNELS-1:0] square;

    logic [MIX_W-1:0] mix_next;
    logic [MIX_W-1:0] mix;
    logic [MIX_W:0]   acc;

    assign ms_tick = (ps_cnt == PS_W'(PRESCALE - 1));
    assign wr_fire = wr.wr_valid && wr.wr_ready;
    assign speaker = acc[MIX_W];

    // Free-running millisecond prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (ms_tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Write port is ready from the first edge after reset onwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr.wr_ready <= 1'b0;
        end else begin
            wr.wr_ready <= 1'b1;
        end
    end

    // Per-voice load, phase toggling and duration countdown.
    // Expiry is evaluated after the phase toggle so it forces square low;
    // a write to the same voice takes priority over both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                div_r[c]   <= '0;
                vol_r[c]   <= '0;
                phase[c]   <= '0;
                dur_cnt[c] <= '0;
            end
            square <= '0;
            active <= '0;
            done   <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                done[c] <= 1'b0;
                if (wr_fire && (wr.wr_ch == CH_W'(c))) begin
                    div_r[c]   <= wr.wr_div;
                    vol_r[c]   <= wr.wr_vol;
                    phase[c]   <= wr.wr_div - DIV_W'(1);
                    dur_cnt[c] <= wr.wr_dur;
                    square[c]  <= 1'b0;
                    active[c]  <= (wr.wr_dur != '0);
                end else if (active[c]) begin
                    if (div_r[c] >= DIV_W'(2)) begin
                        if (phase[c] == '0) begin
                            phase[c]  <= div_r[c] - DIV_W'(1);
                            square[c] <= ~square[c];
                        end else begin
                            phase[c] <= phase[c] - DIV_W'(1);
                        end
                    end
                    if (ms_tick) begin
                        dur_cnt[c] <= dur_cnt[c] - DUR_W'(1);
                        if (dur_cnt[c] == DUR_W'(1)) begin
                            active[c] <= 1'b0;
                            square[c] <= 1'b0;
                            done[c]   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Volume-weighted sum of all sounding voices.
    always_comb begin
        mix_next = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (active[c] && square[c]) begin
                mix_next = mix_next + MIX_W'(vol_r[c]);
            end
        end
    end

    // Registered mix feeding the sigma-delta accumulator; the carry out of
    // the low MIX_W bits is the speaker bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix <= '0;
            acc <= '0;
        end else begin
            mix <= mix_next;
            acc <= {1'b0, acc[MIX_W-1:0]} + {1'b0, mix};
        end
    end
endmodule

// File: tb/tb_tone_voices.sv
// Randomised and directed checks of tone_voices against an event-based
// reference model (note start/end edges, running-total overflow speaker).
module tb_tone_voices;
    localparam int CLK_HZ   = 8000;
    localparam int CHANNELS = 4;
    localparam int DIV_W    = 17;
    localparam int VOL_W    = 4;
    localparam int DUR_W    = 16;
    localparam int PS       = CLK_HZ / 1000;
    localparam int FULL     = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                speaker;
    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] done;

    tone_voices_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .VOL_W(VOL_W), .DUR_W(DUR_W)) wr_if ();

    tone_voices #(
        .CLK_HZ(CLK_HZ), .CHANNELS(CHANNELS), .DIV_W(DIV_W), .VOL_W(VOL_W), .DUR_W(DUR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr_if), .speaker(speaker), .active(active), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: each voice is a note record [start, end) in edge numbers,
    // edge 0 being the last reset edge.
    int     n;
    bit     rdy;
    int     v_start [CHANNELS];
    int     v_end   [CHANNELS];
    int     v_div   [CHANNELS];
    int     v_vol   [CHANNELS];
    bit     v_doneok[CHANNELS];
    longint s_tot;
    int     prev_mix;
    bit     exp_spk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic bit m_active(int c, int m);
        return (v_end[c] >= 0) && (m >= v_start[c]) && (m < v_end[c]);
    endfunction

    function automatic bit m_square(int c, int m);
        if (!m_active(c, m) || v_div[c] < 2) return 1'b0;
        return (((m - v_start[c]) / v_div[c]) % 2) == 1;
    endfunction

    function automatic int m_mix(int m);
        int s = 0;
        for (int c = 0; c < CHANNELS; c++)
            if (m_square(c, m)) s += v_vol[c];
        return s;
    endfunction

    function automatic logic [CHANNELS-1:0] m_active_vec(int m);
        logic [CHANNELS-1:0] v = '0;
        for (int c = 0; c < CHANNELS; c++) v[c] = m_active(c, m);
        return v;
    endfunction

    function automatic logic [CHANNELS-1:0] m_done_vec(int m);
        logic [CHANNELS-1:0] v = '0;
        for (int c = 0; c < CHANNELS; c++) v[c] = v_doneok[c] && (v_end[c] == m);
        return v;
    endfunction

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic step();
        bit acc_w;
        int ch, new_mix;
        @(posedge clk);
        if (!rst_n) begin
            n = 0; rdy = 1'b0; s_tot = 0; prev_mix = 0; exp_spk = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                v_end[c] = -1; v_doneok[c] = 1'b0;
            end
        end else begin
            acc_w = wr_if.wr_valid && rdy;
            ch    = int'(wr_if.wr_ch);
            n++;
            new_mix = m_mix(n - 1);
            exp_spk = ((s_tot + prev_mix) / FULL) != (s_tot / FULL);
            s_tot += prev_mix;
            prev_mix = new_mix;
            rdy = 1'b1;
            if (acc_w && ch < CHANNELS) begin
                v_start[ch] = n;
                v_div[ch]   = int'(wr_if.wr_div);
                v_vol[ch]   = int'(wr_if.wr_vol);
                if (wr_if.wr_dur == '0) begin
                    v_end[ch] = n; v_doneok[ch] = 1'b0;
                end else begin
                    v_end[ch] = (n / PS + int'(wr_if.wr_dur)) * PS;
                    v_doneok[ch] = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, rdy});
        check("active", {28'd0, active}, {28'd0, m_active_vec(n)});
        check("done", {28'd0, done}, {28'd0, rst_n ? m_done_vec(n) : 4'd0});
        check("speaker", {31'd0, speaker}, {31'd0, exp_spk});
    endtask

    task automatic write(input int ch, input int dv, input int vl, input int du);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = ch[1:0];
        wr_if.wr_div   = dv[DIV_W-1:0];
        wr_if.wr_vol   = vl[VOL_W-1:0];
        wr_if.wr_dur   = du[DUR_W-1:0];
        step();
        wr_if.wr_valid = 1'b0;
    endtask

    initial begin
        int len, dones, ones, target;
        n = 0; rdy = 1'b0; s_tot = 0; prev_mix = 0; exp_spk = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_end[c] = -1; v_doneok[c] = 1'b0; v_start[c] = 0; v_div[c] = 0; v_vol[c] = 0;
        end
        wr_if.wr_valid = 1'b0; wr_if.wr_ch = '0; wr_if.wr_div = '0;
        wr_if.wr_vol = '0; wr_if.wr_dur = '0;

        // Reset values
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_speaker", {31'd0, speaker}, 32'd0);
        check("rst_active", {28'd0, active}, 32'd0);
        check("rst_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        check("ready_after_release", {31'd0, wr_if.wr_ready}, 32'd1);
        repeat (5) step();

        // Tone timing
        write(0, 4, 15, 3);
        len = 1; dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (active[0]) len++;
            if (done[0]) dones++;
        end
        check("tone_len_in_range", {31'd0, (len >= 16 && len <= 24)}, 32'd1);
        check("tone_done_once", dones, 32'd1);
        check("tone_speaker_quiet", {31'd0, speaker}, 32'd0);

        // Density: four full-volume voices with long half-periods
        for (int c = 0; c < CHANNELS; c++) write(c, 1000, 15, 200);
        target = v_start[3] + 1000 + 3;
        for (int i = 0; i < 1100 && n < target; i++) step();
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (speaker) ones++;
        end
        check("density_60_of_64", {31'd0, (ones >= 59 && ones <= 61)}, 32'd1);
        for (int c = 0; c < CHANNELS; c++) write(c, 1000, 15, 0);
        repeat (4) step();
        check("idle_speaker", {31'd0, speaker}, 32'd0);

        // Retrigger then stop
        write(1, 6, 9, 3);
        repeat (10) step();
        write(1, 6, 9, 5);
        repeat (20) step();
        write(1, 6, 9, 0);
        check("stop_active1", {31'd0, active[1]}, 32'd0);
        check("stop_no_done", {31'd0, done[1]}, 32'd0);
        repeat (5) step();

        // Write landing on the exact expiry edge
        write(3, 5, 7, 1);
        for (int i = 0; i < 20 && n < v_end[3] - 1; i++) step();
        write(3, 5, 7, 2);
        check("expiry_write_active", {31'd0, active[3]}, 32'd1);
        check("expiry_write_no_done", {31'd0, done[3]}, 32'd0);
        repeat (30) step();

        // Rest voice: timed but silent
        write(2, 0, 15, 2);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done[2]) dones++;
        end
        check("rest_done_once", dones, 32'd1);

        // Reset mid-operation
        write(0, 3, 5, 5);
        write(1, 4, 6, 5);
        write(2, 5, 7, 5);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        check("midrst_active", {28'd0, active}, 32'd0);
        check("midrst_speaker", {31'd0, speaker}, 32'd0);
        rst_n = 1'b1;
        step();
        write(0, 3, 11, 2);
        repeat (30) step();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            wr_if.wr_valid = ($urandom_range(0, 2) == 0);
            wr_if.wr_ch    = 2'($urandom_range(0, CHANNELS - 1));
            wr_if.wr_div   = DIV_W'($urandom_range(0, 12));
            wr_if.wr_vol   = VOL_W'($urandom);
            wr_if.wr_dur   = DUR_W'($urandom_range(0, 4));
            rst_n          = ($urandom_range(0, 499) != 0);
            step();
        end
        wr_if.wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (60) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
